// File: rtl/lap_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared constants, time-value type and lap sequencer state
//                encoding for the stopwatch lap memory path.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int DW    = 24;        // time value / register-file word width
    localparam int AW    = 4;         // register-file address width
    localparam int DEPTH = 1 << AW;   // number of lap slots

    typedef logic [DW-1:0] time_t;

    // Write accesses take three cycles, read accesses three cycles.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        R_SETUP = 3'd4,
        R_PULSE = 3'd5,
        R_CAP   = 3'd6
    } state_e;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/lap_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lap_mem_ctrl_if
//  Description : Bundles the user controls, register-file bus and lap view
//                outputs of the lap memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lap_mem_ctrl_if #(
    parameter int DW = stopwatch_pkg::DW,
    parameter int AW = stopwatch_pkg::AW
);
    // user side
    logic          running;
    logic [DW-1:0] time_in;
    logic          lap_req;
    logic          clr_req;
    logic          nav_next;
    logic          nav_prev;
    // register-file side
    logic          rf_wclk;
    logic          rf_rclk;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_din;
    logic [DW-1:0] rf_dout;
    // status / display side
    logic [AW:0]   lap_count;
    logic [AW-1:0] view_idx;
    logic [DW-1:0] view_data;
    logic          view_valid;
    logic          full;
    logic          busy;

    // Controller view
    modport master (
        input  running, time_in, lap_req, clr_req, nav_next, nav_prev, rf_dout,
        output rf_wclk, rf_rclk, rf_addr, rf_din,
        output lap_count, view_idx, view_data, view_valid, full, busy
    );

    // Environment view (buttons, register file, display)
    modport slave (
        output running, time_in, lap_req, clr_req, nav_next, nav_prev, rf_dout,
        input  rf_wclk, rf_rclk, rf_addr, rf_din,
        input  lap_count, view_idx, view_data, view_valid, full, busy
    );

endinterface : lap_mem_ctrl_if
`default_nettype wire

// File: rtl/lap_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lap_mem_ctrl
//  Description : Sequences the lap register file: snapshots the running time
//                on a lap press, writes it, keeps the lap count, and reads
//                back the selected lap for the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module lap_mem_ctrl #(
    parameter int DW        = stopwatch_pkg::DW,
    parameter int AW        = stopwatch_pkg::AW,
    parameter int OVERWRITE = 0
) (
    input  logic            clk,
    input  logic            rst,
    lap_mem_ctrl_if.master  bus
);
    import stopwatch_pkg::*;

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    state_e        state_q,      state_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0]   count_q,      count_d;
    logic [AW-1:0] view_idx_q,   view_idx_d;
    logic          view_valid_q, view_valid_d;
    logic [DW-1:0] view_data_q,  view_data_d;
    logic [AW-1:0] addr_q,       addr_d;
    logic [DW-1:0] din_q,        din_d;
    logic          pend_q,       pend_d;
    logic [DW-1:0] pend_time_q,  pend_time_d;
    logic          wclk_q;
    logic          rclk_q;

    logic          full_now;
    logic          can_write;
    logic          nav_one;
    logic [AW:0]   last_idx;
    logic [AW-1:0] ptr_after;
    logic [AW:0]   count_after;
    logic          full_after;
    logic [AW:0]   newest_idx;

    // Logical lap index to physical slot; once the ring has wrapped the
    // oldest lap lives at the write pointer.
    function automatic logic [AW-1:0] phys(input logic [AW-1:0] idx,
                                           input logic [AW-1:0] wp,
                                           input logic          is_full);
        if ((OVERWRITE != 0) && is_full) begin
            return idx + wp;
        end
        return idx;
    endfunction

    assign full_now    = (count_q == FULL_CNT);
    assign can_write   = !full_now || (OVERWRITE != 0);
    assign nav_one     = bus.nav_next ^ bus.nav_prev;
    assign last_idx    = count_q - 1'b1;
    assign ptr_after   = wr_ptr_q + 1'b1;
    assign count_after = full_now ? count_q : count_q + 1'b1;
    assign full_after  = (count_after == FULL_CNT);
    assign newest_idx  = count_after - 1'b1;

    // Next-state, address/data and bookkeeping for the strobe sequencer
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        view_idx_d   = view_idx_q;
        view_valid_d = view_valid_q;
        view_data_d  = view_data_q;
        addr_d       = addr_q;
        din_d        = din_q;
        pend_d       = pend_q;
        pend_time_d  = pend_time_q;

        // A lap pressed mid-sequence is parked (one deep) with its own time.
        if ((state_q != IDLE) && bus.lap_req && bus.running && !pend_q) begin
            pend_d      = 1'b1;
            pend_time_d = bus.time_in;
        end

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (can_write) begin
                        state_d = W_SETUP;
                        addr_d  = wr_ptr_q;
                        din_d   = pend_time_q;
                    end
                end else if (bus.lap_req && bus.running && can_write) begin
                    state_d = W_SETUP;
                    addr_d  = wr_ptr_q;
                    din_d   = bus.time_in;
                end else if (nav_one && (count_q != '0)) begin
                    if (bus.nav_next) begin
                        view_idx_d = ({1'b0, view_idx_q} == last_idx) ? '0 : view_idx_q + 1'b1;
                    end else begin
                        view_idx_d = (view_idx_q == '0) ? last_idx[AW-1:0] : view_idx_q - 1'b1;
                    end
                    addr_d  = phys(view_idx_d, wr_ptr_q, full_now);
                    state_d = R_SETUP;
                end
            end
            W_SETUP: state_d = W_PULSE;
            W_PULSE: state_d = W_HOLD;
            W_HOLD: begin
                // Commit the write, then show the lap just recorded.
                wr_ptr_d   = ptr_after;
                count_d    = count_after;
                view_idx_d = newest_idx[AW-1:0];
                addr_d     = phys(newest_idx[AW-1:0], ptr_after, full_after);
                state_d    = R_SETUP;
            end
            R_SETUP: state_d = R_PULSE;
            R_PULSE: state_d = R_CAP;
            R_CAP: begin
                view_data_d  = bus.rf_dout;
                view_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides everything, including a lap in the same cycle.
        if (bus.clr_req) begin
            state_d      = IDLE;
            count_d      = '0;
            wr_ptr_d     = '0;
            view_idx_d   = '0;
            view_valid_d = 1'b0;
            pend_d       = 1'b0;
        end
    end

    // State, bookkeeping and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            view_idx_q   <= '0;
            view_valid_q <= 1'b0;
            view_data_q  <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            pend_q       <= 1'b0;
            pend_time_q  <= '0;
            wclk_q       <= 1'b0;
            rclk_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            view_idx_q   <= view_idx_d;
            view_valid_q <= view_valid_d;
            view_data_q  <= view_data_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            pend_q       <= pend_d;
            pend_time_q  <= pend_time_d;
            wclk_q       <= (state_d == W_PULSE);
            rclk_q       <= (state_d == R_PULSE);
        end
    end

    assign bus.rf_wclk    = wclk_q;
    assign bus.rf_rclk    = rclk_q;
    assign bus.rf_addr    = addr_q;
    assign bus.rf_din     = din_q;
    assign bus.lap_count  = count_q;
    assign bus.view_idx   = view_idx_q;
    assign bus.view_data  = view_data_q;
    assign bus.view_valid = view_valid_q;
    assign bus.full       = full_now;
    assign bus.busy       = (state_q != IDLE);

endmodule : lap_mem_ctrl
`default_nettype wire
